key_reader: RTL and testbench
=============================

# key_reader

Debounced reader for the board's active-low push-buttons: the input-side counterpart to the LED drivers on the same test board. Synchronises each raw key into the clock domain, debounces it, and produces a clean level plus single-cycle press, release and long-press event pulses for downstream control logic (e.g. stepping a colour sequence). One independent state machine per key; all keys share one clock and reset.

## Interface

- `KEYS`, 3: number of keys.
- `DEBOUNCE`, 240000: stable cycles required to accept a press or a release (20 ms at 12 MHz); must be 1..2^32-1.
- `LONG`, 12000000: cycles a debounced press must persist before the long-press event fires (1 s at 12 MHz); must be 1..2^32-1.

- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  asynchronous, active-low reset.
- `key`  input  KEYS  raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `level`  output  KEYS  debounced state, active-high (1 = pressed).
- `press`  output  KEYS  one-cycle pulse when a press is accepted.
- `release`  output  KEYS  one-cycle pulse when a release is accepted.
- `long`  output  KEYS  one-cycle pulse when a held key reaches `LONG`.

## Operation

- Per key: 2-flop synchroniser, reset to 1 (released); its output is `s`.
- Per key: 32-bit counter `cnt`, long flag `lf`, and a 4-state FSM. Reset: state IDLE, `cnt`=0, `lf`=0, all outputs 0.
- IDLE: `s`=0 -> PRESS_DEB, `cnt`<=0.
- PRESS_DEB: `s`=1 -> IDLE (bounce rejected, no event). Else if `cnt`==DEBOUNCE-1 -> HELD, `cnt`<=0, `level`<=1, `press` pulse. Else `cnt`++.
- HELD: `s`=1 -> RELEASE_DEB, `cnt`<=0. Else if `lf`=0 and `cnt`==LONG-1 -> `lf`<=1, `long` pulse, `cnt` holds. Else if `lf`=0, `cnt`++.
- RELEASE_DEB: `s`=0 -> HELD, `cnt`<=0. The long-press timer restarts if `lf`=0; `long` never re-fires if `lf`=1. Else if `cnt`==DEBOUNCE-1 -> IDLE, `level`<=0, `lf`<=0, `release` pulse. Else `cnt`++.
- `level` stays 1 throughout HELD and RELEASE_DEB.
- Events are registered outputs. Each pulse lasts exactly one cycle. A key emits at most one event per cycle.
- Keys are fully independent. Any combination of simultaneous events across keys is legal.
- Counter comparisons are exact equality. `cnt` never wraps.

## Timing

- Edge e0 is the first edge sampling `key`=0. `s` falls at e1. The FSM enters PRESS_DEB at e2. `press` and `level` rise at e(DEBOUNCE+2).
- With DEBOUNCE=1, press latency is 3 cycles.
- `long` is asserted LONG cycles after the `press` pulse, provided `s` stays 0.
- Release latency mirrors press latency: `release` is asserted at e(DEBOUNCE+2) from the first edge sampling `key`=1.
- A bounce shorter than DEBOUNCE+1 cycles of `s` produces no event.
- Reset mid-operation:
  - Asserting `rst` immediately forces all outputs to 0 and all FSMs to IDLE, with no `release` pulse.
  - After deassertion, a key still held is treated as a new press: full debounce, then `press`.

## Structure

- Shared include `key_defs.vh`: FSM state encodings (IDLE, PRESS_DEB, HELD, RELEASE_DEB) and default `DEBOUNCE`/`LONG` constants for 12 MHz.
- Sub-module `key_fsm`: synchroniser, counter and FSM for one key, parameterised by DEBOUNCE/LONG, with scalar ports.
- `key_reader` instantiates `KEYS` copies of `key_fsm` in a generate loop.

## Test plan

Bench parameters are DEBOUNCE=4 and LONG=10.

- Reset, no keys pressed: `key`=3'b111 for 50 cycles -> all outputs remain 0.
- Clean press: `key[0]` low from e0 and held 8 cycles -> `press[0]` pulses at e6, `level[0]`=1 from e6, `long[0]` stays 0.
- Bounce rejection: `key[1]` toggles low 2 cycles, high 1, low 2, then stays high -> no `press[1]`, `level[1]` stays 0.
- Long press and release: `key[2]` low for 30 cycles, then high -> `press[2]` at e6, `long[2]` at e16 exactly once, `release[2]` 6 cycles after the first high sample, then `level[2]`=0.
- Release glitch: after `long[0]` fires, `key[0]` goes high 2 cycles, low 20, then high -> no extra `release`, no second `long`, a single `release[0]` at the end.
- Reset mid-hold: `rst` pulled low while `level[1]`=1 -> `level[1]`=0 with no `release[1]`. After `rst` rises with `key[1]` still low -> `press[1]` 6 cycles later.

Source files
------------

// File: rtl/key_reader_pkg.sv
// key_reader_pkg: shared definitions for the push-button reader.
//   - key_state_e : per-key debounce FSM state encoding
//   - DefDebounce : default debounce window (20 ms at 12 MHz)
//   - DefLong     : default long-press time (1 s at 12 MHz)
package key_reader_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StPressDeb   = 2'd1,
    StHeld       = 2'd2,
    StReleaseDeb = 2'd3
  } key_state_e;

  localparam int unsigned DefDebounce = 32'd240000;
  localparam int unsigned DefLong     = 32'd12000000;

endpackage

// File: rtl/key_fsm.sv
// key_fsm: synchroniser, debounce counter and event FSM for a single active-low key.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   key_i      raw key pin, active-low, asynchronous to clk_i
//   level_o    debounced state, 1 = pressed
//   press_o    one-cycle pulse when a press is accepted
//   release_o  one-cycle pulse when a release is accepted
//   long_o     one-cycle pulse when a held key reaches LONG cycles
module key_fsm
  import key_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned LONG     = DefLong
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [31:0] DebLast  = 32'(DEBOUNCE - 1);
  localparam logic [31:0] LongLast = 32'(LONG - 1);

  // Two-flop synchroniser; resets to 1 so a reset looks like "released".
  logic sync1_q, s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
    end else begin
      sync1_q <= key_i;
      s_q     <= sync1_q;
    end
  end

  key_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        lf_q, lf_d;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lf_d      = lf_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!s_q) begin
          state_d = StPressDeb;
          cnt_d   = '0;
        end
      end
      StPressDeb: begin
        if (s_q) begin
          state_d = StIdle;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StHeld: begin
        if (s_q) begin
          state_d = StReleaseDeb;
          cnt_d   = '0;
        end else if (!lf_q) begin
          // Once the long event has fired the counter parks, so it never wraps.
          if (cnt_q == LongLast) begin
            lf_d   = 1'b1;
            long_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StReleaseDeb: begin
        if (!s_q) begin
          // Release bounce: back to held; lf survives so long cannot re-fire.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          level_d   = 1'b0;
          lf_d      = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      lf_q      <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lf_q      <= lf_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_reader.sv
// key_reader: debounced reader for KEYS active-low push-buttons, one independent
// key_fsm per key sharing a clock and reset.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   key_i      raw key pins, active-low
//   level_o    debounced levels, 1 = pressed
//   press_o    per-key press pulses
//   release_o  per-key release pulses
//   long_o     per-key long-press pulses
module key_reader
  import key_reader_pkg::*;
#(
  parameter int unsigned KEYS     = 3,
  parameter int unsigned DEBOUNCE = DefDebounce,
  parameter int unsigned LONG     = DefLong
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] level_o,
  output logic [KEYS-1:0] press_o,
  output logic [KEYS-1:0] release_o,
  output logic [KEYS-1:0] long_o
);

  for (genvar g = 0; g < KEYS; g++) begin : gen_key
    key_fsm #(
      .DEBOUNCE(DEBOUNCE),
      .LONG    (LONG)
    ) u_key_fsm (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .key_i    (key_i[g]),
      .level_o  (level_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .long_o   (long_o[g])
    );
  end

endmodule

// File: tb/tb_key_reader.sv
module tb_key_reader;

  localparam int unsigned KEYS = 3;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LNG  = 10;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [KEYS-1:0] key_i;
  logic [KEYS-1:0] level_o, press_o, release_o, long_o;

  key_reader #(
    .KEYS    (KEYS),
    .DEBOUNCE(DEB),
    .LONG    (LNG)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .key_i    (key_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o)
  );

  always #5 clk_i = ~clk_i;

  // Posedge count; an event registered at edge N is seen at the next negedge with cyc == N.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum int {EvPress, EvRelease, EvLong} ev_e;
  typedef struct {
    int  k;
    ev_e t;
    int  at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push_ev(input int k, input ev_e t, input int at);
    exp_t e;
    e.k  = k;
    e.t  = t;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int k, input ev_e t);
    int idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].k == k) begin
        idx = i;
        break;
      end
    end
    n_checks++;
    if (idx < 0) begin
      n_errors++;
      $display("FAIL unexpected_event key%0d: got %s at cycle %0d, required none", k, t.name(),
               cyc);
    end else begin
      if (exp_q[idx].t != t || exp_q[idx].at != cyc) begin
        n_errors++;
        $display("FAIL event key%0d: got %s at cycle %0d, required %s at cycle %0d", k,
                 t.name(), cyc, exp_q[idx].t.name(), exp_q[idx].at);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      for (int k = 0; k < KEYS; k++) begin
        if (press_o[k] !== 1'b0)   pop_check(k, EvPress);
        if (release_o[k] !== 1'b0) pop_check(k, EvRelease);
        if (long_o[k] !== 1'b0)    pop_check(k, EvLong);
      end
    end
  end

  task automatic chk_level(input int k, input logic exp);
    n_checks++;
    if (level_o[k] !== exp) begin
      n_errors++;
      $display("FAIL level key%0d at cycle %0d: got %b, required %b", k, cyc, level_o[k], exp);
    end
  endtask

  task automatic chk_idle(input string name);
    n_checks++;
    if ({level_o, press_o, release_o, long_o} !== '0) begin
      n_errors++;
      $display("FAIL %s: got level=%b press=%b release=%b long=%b, required all 0", name,
               level_o, press_o, release_o, long_o);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_ni = 1'b0;
    key_i  = 3'b111;
    #1;
    chk_idle("reset_state");
    wait_n(3);
    rst_ni = 1'b1;

    // Idle for 50 cycles: monitor flags any stray pulse.
    wait_n(50);
    chk_idle("idle_50");

    // Clean press on key0, held 8 samples, then released.
    key_i[0] = 1'b0;
    e0 = cyc + 1;
    push_ev(0, EvPress, e0 + 6);
    wait_n(8);
    chk_level(0, 1'b1);
    key_i[0] = 1'b1;
    push_ev(0, EvRelease, cyc + 1 + 6);
    wait_n(10);
    chk_level(0, 1'b0);

    // Bounce on key1: low 2, high 1, low 2, high.
    key_i[1] = 1'b0;
    wait_n(2);
    key_i[1] = 1'b1;
    wait_n(1);
    key_i[1] = 1'b0;
    wait_n(2);
    key_i[1] = 1'b1;
    wait_n(3);
    chk_level(1, 1'b0);
    wait_n(10);
    chk_level(1, 1'b0);

    // Long press on key2: low 30 cycles then high.
    key_i[2] = 1'b0;
    e0 = cyc + 1;
    push_ev(2, EvPress, e0 + 6);
    push_ev(2, EvLong, e0 + 16);
    wait_n(30);
    chk_level(2, 1'b1);
    key_i[2] = 1'b1;
    push_ev(2, EvRelease, cyc + 1 + 6);
    wait_n(10);
    chk_level(2, 1'b0);

    // Release glitch on key0 after long has fired.
    key_i[0] = 1'b0;
    e0 = cyc + 1;
    push_ev(0, EvPress, e0 + 6);
    push_ev(0, EvLong, e0 + 16);
    wait_n(20);
    key_i[0] = 1'b1;
    wait_n(2);
    key_i[0] = 1'b0;
    wait_n(20);
    chk_level(0, 1'b1);
    key_i[0] = 1'b1;
    push_ev(0, EvRelease, cyc + 1 + 6);
    wait_n(10);
    chk_level(0, 1'b0);

    // Reset while key1 is held: no release, then a fresh press after reset.
    key_i[1] = 1'b0;
    e0 = cyc + 1;
    push_ev(1, EvPress, e0 + 6);
    wait_n(10);
    chk_level(1, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_idle("reset_mid_hold");
    wait_n(3);
    rst_ni = 1'b1;
    push_ev(1, EvPress, cyc + 1 + 6);
    wait_n(5);
    chk_level(1, 1'b0);
    wait_n(5);
    chk_level(1, 1'b1);
    key_i[1] = 1'b1;
    push_ev(1, EvRelease, cyc + 1 + 6);
    wait_n(12);
    chk_level(1, 1'b0);

    // Every expected event must have been presented.
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      for (int i = 0; i < exp_q.size(); i++)
        $display("FAIL missing_event key%0d: got nothing, required %s at cycle %0d", exp_q[i].k,
                 exp_q[i].t.name(), exp_q[i].at);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
